uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a write FIFO, optional parity, 1 or 2 stop bits, CTS flow control and a WAKEUP pre-pulse for an attached radio module. It replaces the fixed 8N1 transmitter driving TxD/RTS/WAKEUP in top. The CPU-side bus writes bytes into the FIFO; the block serialises them onto TxD autonomously.

Parameters:
BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
WAKE_CYCLES, 1000, WAKEUP high time before a frame that follows a long idle; 0 disables WAKEUP
IDLE_WAKE, 50000, idle cycles after which the next frame needs a WAKEUP pre-pulse

Ports:
clock  in  1  system clock
n_rst  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, one entry per cycle
wr_data  in  DATA_BITS  byte to enqueue
CTS_n  in  1  clear-to-send, active low, asynchronous; 2-flop synchronised
full  out  1  FIFO full
empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  one-cycle pulse when a write is dropped
busy  out  1  high when state is not IDLE
TxD  out  1  serial output, idle high
RTS  out  1  active low; low while FIFO is non-empty or busy
WAKEUP  out  1  high during the WAKE state

Behaviour:
- One clock; reset is asynchronous and active-low (n_rst). Asserting n_rst mid-frame aborts the frame immediately.
- Reset values: TxD=1, RTS=1, WAKEUP=0, busy=0, full=0, empty=1, count=0, overflow=0. FIFO pointers are 0, the idle counter is saturated, and the synchroniser is preset to 1 (not clear).
- FIFO: circular buffer with read/write pointers and a registered count. full and empty are derived from count.
  - A write with full=1 is dropped and overflow pulses on the next cycle. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves count unchanged.
- Pop: occurs on the cycle the FSM leaves IDLE (to WAKE or START). The popped word is latched into the shift register.
- FSM states: IDLE, WAKE, START, DATA, PAR, STOP.
  - IDLE -> (empty=0 and synchronised CTS_n=0): goes to WAKE if WAKE_CYCLES>0 and idle counter >= IDLE_WAKE, otherwise to START.
  - WAKE: lasts WAKE_CYCLES cycles with TxD=1, then START.
  - START: 1 bit, TxD=0.
  - DATA: DATA_BITS bits, LSB first.
  - PAR: 1 bit, present only if PARITY!=0. Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: STOP_BITS bits, TxD=1.
  - After the last stop bit: if empty=0 and CTS_n=0, go directly to START with the next pop (no idle gap, no WAKE); otherwise go to IDLE.
- Bit timing: a baud counter reloads to BAUD_DIV-1 at each bit start; the bit ends when it reaches 0. Each bit is exactly BAUD_DIV cycles.
- TxD is driven from a register (glitch-free).
- Latency: with the FSM in IDLE, CTS_n already synchronised low and no wake pending, TxD falls 2 cycles after the clock edge that samples wr_en=1.
- CTS_n is evaluated only at frame boundaries. Deasserting it mid-frame does not stop the current frame.
- Idle counter: saturating, counts cycles in IDLE, clears on leaving IDLE. It is saturated out of reset, so the first frame after reset always gets WAKE when WAKE_CYCLES>0.
- RTS = ~(~empty | busy), registered; one cycle behind the FIFO/FSM state.
- count width covers 0..FIFO_DEPTH inclusive. Pointer wrap-around is modulo FIFO_DEPTH.

Test Plan:
1. BAUD_DIV=4, 8N1, WAKE_CYCLES=0, CTS_n=0; write 0x55 -> TxD falls 2 cycles later; the sequence 0,1,0,1,0,1,0,1,0,1 is held 4 cycles per bit, then stays 1; busy is high for 40 cycles; RTS returns high afterwards.
2. Same config; write 0xA3, 0x0F on consecutive cycles -> two frames back-to-back, 80 cycles total, no idle gap between the stop bit and the second start bit; count goes 1,2,1,0.
3. PARITY=1, STOP_BITS=2; write 0x07 -> parity bit 1 and two stop bits; frame is 48 cycles. With PARITY=2 the parity bit is 0.
4. FIFO_DEPTH=4, CTS_n=1; write 5 bytes -> full=1 after the 4th write, the 5th is dropped with a one-cycle overflow pulse, count=4, TxD stays 1. Release CTS_n -> 4 frames are sent in write order.
5. WAKE_CYCLES=10, IDLE_WAKE=100; the first write after reset -> WAKEUP is high for 10 cycles, then the start bit. A second write 20 cycles after the frame ends gets no WAKE. A write after more than 100 idle cycles gets WAKE again.
6. Assert n_rst mid-DATA -> TxD=1, busy=0, count=0 and WAKEUP=0 immediately (asynchronously); the next write after release transmits normally.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: byte strobe in, FIFO status out.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;

  modport master (output wr_en, output wr_data,
                  input full, input empty, input count, input overflow);
  modport slave  (input wr_en, input wr_data,
                  output full, output empty, output count, output overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, optional parity, 1/2 stop bits,
// CTS flow control and a WAKEUP pre-pulse after long idle periods.
//
// state | meaning
// IDLE  | line idle, waiting for data and CTS
// WAKE  | WAKEUP high, TxD high, radio waking up
// START | start bit (TxD=0)
// DATA  | data bits, LSB first
// PAR   | parity bit
// STOP  | stop bit(s), TxD=1
module uart_tx_fifo #(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int WAKE_CYCLES = 1000,
  parameter int IDLE_WAKE   = 50000
) (
  input  logic            clock,
  input  logic            n_rst,
  uart_tx_fifo_if.slave   bus,
  input  logic            CTS_n,
  output logic            busy,
  output logic            TxD,
  output logic            RTS,
  output logic            WAKEUP
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(IDLE_WAKE + 2);
  localparam int WW = $clog2(WAKE_CYCLES + 2);

  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
  localparam logic [WW-1:0] WAKE_LOAD = WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDLE_LIM  = IW'(IDLE_WAKE);
  localparam logic [3:0]    DATA_LOAD = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LOAD = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          WAKE_EN   = (WAKE_CYCLES > 0);

  typedef enum logic [2:0] {IDLE, WAKE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 avail_q, avail_d;
  logic                 cts_meta_q, cts_sync_q;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [WW-1:0]        wake_q, wake_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic                 txd_q, txd_d;
  logic                 rts_q, rts_d;
  logic                 full_w, empty_w, wr_accept, pop, go, bit_end;

  assign full_w  = (count_q == CW'(FIFO_DEPTH));
  assign empty_w = (count_q == '0);

  // FIFO bookkeeping; a write into a full FIFO is dropped even when a pop
  // frees a slot in the same cycle. avail_q is a registered non-empty flag:
  // the FSM only looks at it at frame boundaries, so the one-cycle lag only
  // delays the first frame after idle.
  always_comb begin
    wr_accept  = bus.wr_en & ~full_w;
    overflow_d = bus.wr_en & full_w;
    wr_ptr_d   = wr_accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_accept) - CW'(pop);
    avail_d    = ~empty_w;
    rts_d      = empty_w & (state_q == IDLE);
    if (state_q != IDLE)   idle_d = '0;
    else if (&idle_q)      idle_d = idle_q;
    else                   idle_d = idle_q + IW'(1);
  end

  // FSM next state, bit timing, pop and TxD value for the next cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    wake_d  = wake_q;
    pop     = 1'b0;
    bit_end = (baud_q == '0);
    go      = avail_q & ~cts_sync_q;
    case (state_q)
      IDLE: if (go) begin
        pop    = 1'b1;
        baud_d = BAUD_LOAD;
        if (WAKE_EN && idle_q >= IDLE_LIM) begin
          state_d = WAKE;
          wake_d  = WAKE_LOAD;
        end else begin
          state_d = START;
        end
      end
      WAKE: if (wake_q == '0) begin
        state_d = START;
        baud_d  = BAUD_LOAD;
      end else begin
        wake_d = wake_q - WW'(1);
      end
      START: if (bit_end) begin
        state_d = DATA;
        baud_d  = BAUD_LOAD;
        bit_d   = DATA_LOAD;
      end else begin
        baud_d = baud_q - BW'(1);
      end
      DATA: if (bit_end) begin
        baud_d  = BAUD_LOAD;
        shift_d = shift_q >> 1;
        if (bit_q == '0) begin
          state_d = HAS_PAR ? PAR : STOP;
          bit_d   = STOP_LOAD;
        end else begin
          bit_d = bit_q - 4'd1;
        end
      end else begin
        baud_d = baud_q - BW'(1);
      end
      PAR: if (bit_end) begin
        state_d = STOP;
        baud_d  = BAUD_LOAD;
        bit_d   = STOP_LOAD;
      end else begin
        baud_d = baud_q - BW'(1);
      end
      STOP: if (bit_end) begin
        baud_d = BAUD_LOAD;
        if (bit_q != '0) begin
          bit_d = bit_q - 4'd1;
        end else if (go) begin
          state_d = START;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        baud_d = baud_q - BW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ ODD;
    end
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clock) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // State registers; reset aborts any frame in progress
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      avail_q    <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wake_q     <= '0;
      idle_q     <= '1;
      txd_q      <= 1'b1;
      rts_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      avail_q    <= avail_d;
      cts_meta_q <= CTS_n;
      cts_sync_q <= cts_meta_q;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wake_q     <= wake_d;
      idle_q     <= idle_d;
      txd_q      <= txd_d;
      rts_q      <= rts_d;
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign busy         = (state_q != IDLE);
  assign WAKEUP       = (state_q == WAKE);
  assign TxD          = txd_q;
  assign RTS          = rts_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three configurations sharing clock/reset.
// a: 8N1, FIFO 4, no wake; b: even parity, 2 stop, wake 10/100; c: odd parity, 2 stop.
module tb_uart_tx_fifo;
  logic clock = 1'b0;
  logic n_rst = 1'b1;
  logic cts_a = 1'b0, cts_b = 1'b0, cts_c = 1'b0;
  logic busy_a, txd_a, rts_a, wake_a;
  logic busy_b, txd_b, rts_b, wake_b;
  logic busy_c, txd_c, rts_c, wake_c;
  int checks = 0;
  int errors = 0;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_c ();

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1),
                 .WAKE_CYCLES(0), .IDLE_WAKE(100)) dut_a (
    .clock(clock), .n_rst(n_rst), .bus(if_a.slave), .CTS_n(cts_a),
    .busy(busy_a), .TxD(txd_a), .RTS(rts_a), .WAKEUP(wake_a));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(2),
                 .WAKE_CYCLES(10), .IDLE_WAKE(100)) dut_b (
    .clock(clock), .n_rst(n_rst), .bus(if_b.slave), .CTS_n(cts_b),
    .busy(busy_b), .TxD(txd_b), .RTS(rts_b), .WAKEUP(wake_b));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2),
                 .WAKE_CYCLES(0), .IDLE_WAKE(100)) dut_c (
    .clock(clock), .n_rst(n_rst), .bus(if_c.slave), .CTS_n(cts_c),
    .busy(busy_c), .TxD(txd_c), .RTS(rts_c), .WAKEUP(wake_c));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input int s);
    case (s)
      0:       return txd_a;
      1:       return txd_b;
      default: return txd_c;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic wr(input int s, input logic [7:0] d);
    case (s)
      0:       begin if_a.wr_en = 1'b1; if_a.wr_data = d; end
      1:       begin if_b.wr_en = 1'b1; if_b.wr_data = d; end
      default: begin if_c.wr_en = 1'b1; if_c.wr_data = d; end
    endcase
    tick();
    if_a.wr_en = 1'b0;
    if_b.wr_en = 1'b0;
    if_c.wr_en = 1'b0;
  endtask

  // Called at the sample where the start bit is already on TxD; returns at
  // the sample of the last stop-bit cycle.
  task automatic check_frame(input int s, input logic [7:0] d, input int par,
                             input int stops, input string tag);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (par == 1) begin bits[n] = ^d; n++; end
    else if (par == 2) begin bits[n] = ~(^d); n++; end
    n += stops;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (b != 0 || c != 0) tick();
        chk($sformatf("%s bit%0d", tag, b), 32'(txd_of(s)), 32'(bits[b]));
        chk($sformatf("%s busy", tag), 32'(busy_of(s)), 32'd1);
      end
    end
  endtask

  task automatic wait_start(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (txd_of(s) !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(txd_of(s)), 32'd0);
  endtask

  // From the sample right after a write on instance b: expects a 10-cycle
  // WAKEUP pulse with TxD high, followed directly by the start bit.
  task automatic wake_phase(input string tag);
    int wl;
    wl = 0;
    tick();
    chk({tag, " no wake yet"}, 32'(wake_b), 32'd0);
    tick();
    while (wake_b === 1'b1 && wl < 50) begin
      chk({tag, " txd during wake"}, 32'(txd_b), 32'd1);
      wl++;
      tick();
    end
    chk({tag, " wake length"}, 32'(wl), 32'd10);
    chk({tag, " start after wake"}, 32'(txd_b), 32'd0);
  endtask

  initial begin
    if_a.wr_en = 1'b0; if_a.wr_data = '0;
    if_b.wr_en = 1'b0; if_b.wr_data = '0;
    if_c.wr_en = 1'b0; if_c.wr_data = '0;
    #1 n_rst = 1'b0;
    #1;
    chk("rst txd", 32'(txd_a), 32'd1);
    chk("rst rts", 32'(rts_a), 32'd1);
    chk("rst wakeup", 32'(wake_b), 32'd0);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst full", 32'(if_a.full), 32'd0);
    chk("rst empty", 32'(if_a.empty), 32'd1);
    chk("rst count", 32'(if_a.count), 32'd0);
    chk("rst overflow", 32'(if_a.overflow), 32'd0);
    tick();
    tick();
    n_rst = 1'b1;
    repeat (3) tick();

    // single 8N1 frame, latency, busy length, RTS
    wr(0, 8'h55);
    chk("t1 count", 32'(if_a.count), 32'd1);
    chk("t1 txd P1", 32'(txd_a), 32'd1);
    tick();
    chk("t1 txd P2", 32'(txd_a), 32'd1);
    chk("t1 busy P2", 32'(busy_a), 32'd0);
    chk("t1 rts P2", 32'(rts_a), 32'd0);
    tick();
    check_frame(0, 8'h55, 0, 1, "t1");
    tick();
    chk("t1 busy end", 32'(busy_a), 32'd0);
    chk("t1 txd end", 32'(txd_a), 32'd1);
    chk("t1 rts lag", 32'(rts_a), 32'd0);
    tick();
    chk("t1 rts high", 32'(rts_a), 32'd1);
    chk("t1 empty", 32'(if_a.empty), 32'd1);

    // back-to-back frames, count 1,2,1,0
    wr(0, 8'hA3);
    chk("t2 count1", 32'(if_a.count), 32'd1);
    wr(0, 8'h0F);
    chk("t2 count2", 32'(if_a.count), 32'd2);
    chk("t2 txd idle", 32'(txd_a), 32'd1);
    tick();
    chk("t2 count pop1", 32'(if_a.count), 32'd1);
    check_frame(0, 8'hA3, 0, 1, "t2 f1");
    tick();
    chk("t2 count pop2", 32'(if_a.count), 32'd0);
    check_frame(0, 8'h0F, 0, 1, "t2 f2");
    tick();
    chk("t2 busy end", 32'(busy_a), 32'd0);

    // odd parity, 2 stop bits
    wr(2, 8'h07);
    tick();
    tick();
    check_frame(2, 8'h07, 2, 2, "t3 odd");
    tick();
    chk("t3 odd busy end", 32'(busy_c), 32'd0);

    // even parity, 2 stop bits, first frame after reset gets WAKE
    wr(1, 8'h07);
    wake_phase("t5 first");
    check_frame(1, 8'h07, 1, 2, "t3 even");
    tick();
    chk("t3 even busy end", 32'(busy_b), 32'd0);
    repeat (20) tick();
    wr(1, 8'h81);
    tick();
    tick();
    chk("t5 short idle wake", 32'(wake_b), 32'd0);
    chk("t5 short idle start", 32'(txd_b), 32'd0);
    check_frame(1, 8'h81, 1, 2, "t5 short");
    tick();
    repeat (120) tick();
    wr(1, 8'h3C);
    wake_phase("t5 long idle");
    check_frame(1, 8'h3C, 1, 2, "t5 long");
    tick();
    chk("t5 busy end", 32'(busy_b), 32'd0);

    // FIFO full, overflow, CTS hold-off, write order
    cts_a = 1'b1;
    repeat (3) tick();
    wr(0, 8'h11);
    wr(0, 8'h22);
    wr(0, 8'h33);
    chk("t4 not full", 32'(if_a.full), 32'd0);
    wr(0, 8'h44);
    chk("t4 full", 32'(if_a.full), 32'd1);
    chk("t4 count4", 32'(if_a.count), 32'd4);
    chk("t4 no overflow", 32'(if_a.overflow), 32'd0);
    wr(0, 8'hEE);
    chk("t4 overflow", 32'(if_a.overflow), 32'd1);
    chk("t4 count kept", 32'(if_a.count), 32'd4);
    tick();
    chk("t4 overflow pulse", 32'(if_a.overflow), 32'd0);
    repeat (5) tick();
    chk("t4 txd held", 32'(txd_a), 32'd1);
    chk("t4 busy held", 32'(busy_a), 32'd0);
    cts_a = 1'b0;
    tick();
    tick();
    wr(0, 8'hFF);
    chk("t4 overflow with pop", 32'(if_a.overflow), 32'd1);
    chk("t4 count after pop", 32'(if_a.count), 32'd3);
    check_frame(0, 8'h11, 0, 1, "t4 f1");
    if_a.wr_en = 1'b1;
    if_a.wr_data = 8'h99;
    tick();
    if_a.wr_en = 1'b0;
    chk("t4 write+pop count", 32'(if_a.count), 32'd3);
    check_frame(0, 8'h22, 0, 1, "t4 f2");
    tick();
    check_frame(0, 8'h33, 0, 1, "t4 f3");
    tick();
    check_frame(0, 8'h44, 0, 1, "t4 f4");
    tick();
    check_frame(0, 8'h99, 0, 1, "t4 f5");
    tick();
    chk("t4 busy end", 32'(busy_a), 32'd0);
    chk("t4 count end", 32'(if_a.count), 32'd0);

    // asynchronous reset mid-DATA, then a normal frame
    wr(0, 8'h5A);
    wr(0, 8'h6B);
    wait_start(0, 10, "t6 start");
    repeat (10) tick();
    chk("t6 in frame", 32'(busy_a), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("t6 rst txd", 32'(txd_a), 32'd1);
    chk("t6 rst busy", 32'(busy_a), 32'd0);
    chk("t6 rst count", 32'(if_a.count), 32'd0);
    chk("t6 rst wakeup", 32'(wake_b), 32'd0);
    chk("t6 rst rts", 32'(rts_a), 32'd1);
    #1 n_rst = 1'b1;
    wr(0, 8'hC3);
    wait_start(0, 20, "t6 restart");
    check_frame(0, 8'hC3, 0, 1, "t6");
    tick();
    chk("t6 busy end", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
